// File: rtl/cpu_writeback_bank_reg.sv
// Writeback select plus general-purpose register bank with two async read ports
// and a forwarding tap. Optional same-cycle write-through: CPU_BANK_REG_BYPASS_EN.
module cpu_writeback_bank_reg #(
    parameter  int DATA_WIDTH = 32,
    parameter  int REG_COUNT  = 16,
    localparam int ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wb_reg_write,
    input  logic                  wb_mem_to_reg,
    input  logic [ADDR_WIDTH-1:0] wb_reg_dest,
    input  logic [DATA_WIDTH-1:0] wb_alu_data,
    input  logic [DATA_WIDTH-1:0] wb_mem_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  fwd_valid,
    output logic [ADDR_WIDTH-1:0] fwd_dest,
    output logic [DATA_WIDTH-1:0] fwd_data
);

    logic [DATA_WIDTH-1:0] reg_file [REG_COUNT];
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;

    // Ternary mux keeps an undriven load bus out of the ALU path.
    assign wr_data = wb_mem_to_reg ? wb_mem_data : wb_alu_data;
    assign wr_en   = wb_reg_write && (wb_reg_dest != '0);

    assign fwd_valid = wr_en;
    assign fwd_dest  = wb_reg_dest;
    assign fwd_data  = wr_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                reg_file[i] <= '0;
            end
        end else if (wr_en) begin
            reg_file[wb_reg_dest] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = '0;
        if (rd_addr_a != '0) begin
            rd_data_a = reg_file[rd_addr_a];
        end
`ifdef CPU_BANK_REG_BYPASS_EN
        if (reset && wr_en && (rd_addr_a == wb_reg_dest)) begin
            rd_data_a = wr_data;
        end
`endif
    end

    always_comb begin
        rd_data_b = '0;
        if (rd_addr_b != '0) begin
            rd_data_b = reg_file[rd_addr_b];
        end
`ifdef CPU_BANK_REG_BYPASS_EN
        if (reset && wr_en && (rd_addr_b == wb_reg_dest)) begin
            rd_data_b = wr_data;
        end
`endif
    end

endmodule

// File: tb/tb_cpu_writeback_bank_reg.sv
// Self-checking bench for cpu_writeback_bank_reg: vector table, scoreboard queue
// for post-edge reads, hand-written async reset sequence.
module tb_cpu_writeback_bank_reg;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic [3:0]  wb_reg_dest;
    logic [31:0] wb_alu_data;
    logic [31:0] wb_mem_data;
    logic [3:0]  rd_addr_a;
    logic [31:0] rd_data_a;
    logic [3:0]  rd_addr_b;
    logic [31:0] rd_data_b;
    logic        fwd_valid;
    logic [3:0]  fwd_dest;
    logic [31:0] fwd_data;

`ifdef CPU_BANK_REG_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    cpu_writeback_bank_reg dut (
        .clock        (clock),
        .reset        (reset),
        .wb_reg_write (wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg),
        .wb_reg_dest  (wb_reg_dest),
        .wb_alu_data  (wb_alu_data),
        .wb_mem_data  (wb_mem_data),
        .rd_addr_a    (rd_addr_a),
        .rd_data_a    (rd_data_a),
        .rd_addr_b    (rd_addr_b),
        .rd_data_b    (rd_data_b),
        .fwd_valid    (fwd_valid),
        .fwd_dest     (fwd_dest),
        .fwd_data     (fwd_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        w;
        logic        m;
        logic [3:0]  d;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [3:0]  a;
        logic [3:0]  b;
        logic        fv;
        logic [31:0] fd;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    typedef struct {
        logic [31:0] ea;
        logic [31:0] eb;
    } sb_t;

    vec_t        vecs [9];
    sb_t         sb [$];
    logic [31:0] model [16];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pre_read(input logic [3:0] addr, input vec_t v);
        logic [31:0] data;
        data = v.m ? v.mem : v.alu;
        if (addr == 4'd0) return 32'h0;
        if (BYP && v.w && v.d != 4'd0 && addr == v.d) return data;
        return model[addr];
    endfunction

    task automatic apply(input vec_t v, input int idx);
        sb_t e;
        @(negedge clock);
        wb_reg_write  = v.w;
        wb_mem_to_reg = v.m;
        wb_reg_dest   = v.d;
        wb_alu_data   = v.alu;
        wb_mem_data   = v.mem;
        rd_addr_a     = v.a;
        rd_addr_b     = v.b;
        #1;
        chk($sformatf("v%0d fwd_valid", idx), {31'b0, fwd_valid}, {31'b0, v.fv});
        chk($sformatf("v%0d fwd_dest", idx), {28'b0, fwd_dest}, {28'b0, v.d});
        chk($sformatf("v%0d fwd_data", idx), fwd_data, v.fd);
        chk($sformatf("v%0d pre rd_a", idx), rd_data_a, pre_read(v.a, v));
        chk($sformatf("v%0d pre rd_b", idx), rd_data_b, pre_read(v.b, v));
        e.ea = v.ea;
        e.eb = v.eb;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL v%0d scoreboard empty", idx);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d post rd_a", idx), rd_data_a, e.ea);
            chk($sformatf("v%0d post rd_b", idx), rd_data_b, e.eb);
        end
        if (v.w && v.d != 4'd0) model[v.d] = v.m ? v.mem : v.alu;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        //            w     m     d      alu           mem           a      b      fv    fd            ea            eb
        vecs[0] = '{1'b1, 1'b0, 4'd1,  32'h4,        32'h0,        4'd1,  4'd1,  1'b1, 32'h4,        32'h4,        32'h4};
        vecs[1] = '{1'b1, 1'b0, 4'd1,  32'h1,        32'h0,        4'd1,  4'd0,  1'b1, 32'h1,        32'h1,        32'h0};
        vecs[2] = '{1'b1, 1'b1, 4'd5,  32'h12345678, 32'hDEADBEEF, 4'd5,  4'd1,  1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h1};
        vecs[3] = '{1'b0, 1'b0, 4'd3,  32'hFF,       32'h0,        4'd3,  4'd5,  1'b0, 32'hFF,       32'h0,        32'hDEADBEEF};
        vecs[4] = '{1'b1, 1'b0, 4'd0,  32'h55,       32'h0,        4'd0,  4'd0,  1'b0, 32'h55,       32'h0,        32'h0};
        vecs[5] = '{1'b1, 1'b0, 4'd6,  32'h66,       32'hx,        4'd6,  4'd6,  1'b1, 32'h66,       32'h66,       32'h66};
        vecs[6] = '{1'b1, 1'b0, 4'd2,  32'h1,        32'h0,        4'd2,  4'd1,  1'b1, 32'h1,        32'h1,        32'h1};
        vecs[7] = '{1'b1, 1'b0, 4'd2,  32'h9,        32'h0,        4'd2,  4'd2,  1'b1, 32'h9,        32'h9,        32'h9};
        vecs[8] = '{1'b1, 1'b1, 4'd15, 32'h0,        32'hFFFFFFFF, 4'd15, 4'd2,  1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h9};

        for (int i = 0; i < 16; i++) model[i] = 32'h0;

        reset         = 1'b0;
        wb_reg_write  = 1'b0;
        wb_mem_to_reg = 1'b0;
        wb_reg_dest   = 4'd0;
        wb_alu_data   = 32'h0;
        wb_mem_data   = 32'h0;
        rd_addr_a     = 4'd1;
        rd_addr_b     = 4'd2;
        #2;
        chk("reset rd_a", rd_data_a, 32'h0);
        chk("reset rd_b", rd_data_b, 32'h0);
        chk("reset fwd_valid", {31'b0, fwd_valid}, 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) apply(vecs[i], i);

        // Async reset in the middle of a write.
        v = '{1'b1, 1'b0, 4'd7, 32'hA5A5A5A5, 32'h0, 4'd7, 4'd0, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0};
        apply(v, 9);
        @(negedge clock);
        wb_reg_write = 1'b1;
        wb_reg_dest  = 4'd7;
        wb_alu_data  = 32'h1234;
        rd_addr_a    = 4'd7;
        rd_addr_b    = 4'd15;
        #2;
        reset = 1'b0;
        #1;
        chk("async rd_a", rd_data_a, 32'h0);
        chk("async rd_b", rd_data_b, 32'h0);
        chk("async fwd_valid", {31'b0, fwd_valid}, 32'h1);
        chk("async fwd_data", fwd_data, 32'h1234);
        @(posedge clock);
        #1;
        chk("reset write ignored", rd_data_a, 32'h0);
        @(negedge clock);
        wb_reg_write = 1'b0;
        reset = 1'b1;
        #1;
        chk("after release rd_a", rd_data_a, 32'h0);
        chk("after release rd_b", rd_data_b, 32'h0);
        for (int i = 0; i < 16; i++) model[i] = 32'h0;

        // First edge after release commits.
        v = '{1'b1, 1'b0, 4'd7, 32'h77, 32'h0, 4'd7, 4'd5, 1'b1, 32'h77, 32'h77, 32'h0};
        apply(v, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
